// File: rtl/filling_pkg.sv
// filling_pkg: shared state encoding and BCD limit for the filling tank controller.
package filling_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2,
        ST_FAULT   = 2'd3
    } state_e;
    localparam logic [3:0] BCD_MAX = 4'd9;
endpackage

// File: rtl/bcd2_to_bin.sv
// bcd2_to_bin: converts a two-digit BCD number to a 7-bit binary value.
// Ports: tens_i/units_i BCD digits in; value_o = 10*tens+units; valid_o = both digits <= 9.
module bcd2_to_bin
    import filling_pkg::*;
(
    input  logic [3:0] tens_i,
    input  logic [3:0] units_i,
    output logic [6:0] value_o,
    output logic       valid_o
);
    logic [7:0] sum;
    // Invalid digits still produce a (meaningless) truncated value; valid_o flags them.
    assign sum     = 8'(tens_i) * 8'd10 + 8'(units_i);
    assign value_o = sum[6:0];
    assign valid_o = (tens_i <= BCD_MAX) && (units_i <= BCD_MAX);
endmodule

// File: rtl/filling_tank_controller.sv
// filling_tank_controller: fills a tank to a BCD setpoint with hysteresis, stall watchdog and fault latch.
// Ports: clk/reset (sync, active-high); level_* and setpoint_* BCD digits; start/stop/clear_fault
// requests; valve_open/full/fault Moore outputs; state = IDLE 0, FILLING 1, FULL 2, FAULT 3.
module filling_tank_controller
    import filling_pkg::*;
#(
    parameter int WD_CYCLES = 1000,
    parameter int HYST      = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] level_units,
    input  logic [3:0] level_tens,
    input  logic [3:0] setpoint_units,
    input  logic [3:0] setpoint_tens,
    input  logic       start,
    input  logic       stop,
    input  logic       clear_fault,
    output logic       valve_open,
    output logic       full,
    output logic       fault,
    output logic [1:0] state
);
    localparam int WD_W = $clog2(WD_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);

    logic [6:0]      level, setpoint, prev_q;
    logic            level_ok, setpoint_ok, ok;
    logic            above, low, stalled, wd_exp;
    logic [WD_W-1:0] wd_q, wd_d, wd_inc;
    state_e          state_q, state_d;
    logic            valve_q, full_q, fault_q;

    bcd2_to_bin u_level (
        .tens_i  (level_tens),
        .units_i (level_units),
        .value_o (level),
        .valid_o (level_ok)
    );

    bcd2_to_bin u_setpoint (
        .tens_i  (setpoint_tens),
        .units_i (setpoint_units),
        .value_o (setpoint),
        .valid_o (setpoint_ok)
    );

    assign ok      = level_ok && setpoint_ok;
    assign above   = level >= setpoint;
    // Refill only once the level has sagged more than HYST below target.
    assign low     = ({1'b0, level} + 8'(HYST)) < {1'b0, setpoint};
    assign stalled = level == prev_q;
    assign wd_inc  = wd_q + WD_W'(1);
    assign wd_exp  = stalled && (wd_inc == WD_LAST);

    // Ternary chains encode the priority: invalid BCD > stop > at target > watchdog > start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    state_d = !ok ? ST_FAULT : stop ? ST_IDLE :
                                  start ? (above ? ST_FULL : ST_FILLING) : ST_IDLE;
            ST_FILLING: state_d = !ok ? ST_FAULT : stop ? ST_IDLE : above ? ST_FULL :
                                  wd_exp ? ST_FAULT : ST_FILLING;
            ST_FULL:    state_d = !ok ? ST_FAULT : stop ? ST_IDLE : low ? ST_FILLING : ST_FULL;
            default:    state_d = (ok && clear_fault) ? ST_IDLE : ST_FAULT;
        endcase
        // Counter only runs while staying in FILLING with a frozen level; entry clears it.
        wd_d = (state_q == ST_FILLING && state_d == ST_FILLING && stalled) ? wd_inc : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wd_q    <= '0;
            prev_q  <= '0;
            valve_q <= 1'b0;
            full_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            prev_q  <= level;
            valve_q <= state_d == ST_FILLING;
            full_q  <= state_d == ST_FULL;
            fault_q <= state_d == ST_FAULT;
        end
    end

    assign valve_open = valve_q;
    assign full       = full_q;
    assign fault      = fault_q;
    assign state      = state_q;
endmodule

// File: tb/tb_filling_tank_controller.sv
// tb_filling_tank_controller: directed and random checks of the tank controller against a reference model.
module tb_filling_tank_controller;
    localparam int WD = 8;
    localparam int HY = 5;

    logic       clk = 1'b0;
    logic       reset, start, stop, clr;
    logic [3:0] lu, lt, su, st;
    logic       valve, full, fault;
    logic [1:0] state;

    int total = 0, bad = 0;
    int m_state = 0, m_prev = 0, m_mark = 0, ecnt = 0;

    filling_tank_controller #(.WD_CYCLES(WD), .HYST(HY)) dut (
        .clk            (clk),
        .reset          (reset),
        .level_units    (lu),
        .level_tens     (lt),
        .setpoint_units (su),
        .setpoint_tens  (st),
        .start          (start),
        .stop           (stop),
        .clear_fault    (clr),
        .valve_open     (valve),
        .full           (full),
        .fault          (fault),
        .state          (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_lvl(input int v);
        lt = 4'(v / 10);
        lu = 4'(v % 10);
    endtask

    task automatic set_sp(input int v);
        st = 4'(v / 10);
        su = 4'(v % 10);
    endtask

    // Reference model: level bookkeeping by arithmetic; the watchdog is tracked as the edge
    // number of the last FILLING entry or level change, expiring WD-1 edges later.
    task automatic model_update();
        int  lvl, sp, nxt;
        bit  ok, same;
        ecnt++;
        if (reset) begin
            m_state = 0;
            m_prev  = 0;
            return;
        end
        ok   = lu <= 9 && lt <= 9 && su <= 9 && st <= 9;
        lvl  = (10 * int'(lt) + int'(lu)) % 128;
        sp   = (10 * int'(st) + int'(su)) % 128;
        same = lvl == m_prev;
        nxt  = m_state;
        if (m_state == 3) nxt = (ok && clr) ? 0 : 3;
        else if (!ok) nxt = 3;
        else if (stop) nxt = 0;
        else if (m_state == 0) nxt = start ? ((lvl >= sp) ? 2 : 1) : 0;
        else if (m_state == 1) begin
            if (lvl >= sp) nxt = 2;
            else if (same && ecnt - m_mark >= WD - 1) nxt = 3;
        end else if (lvl + HY < sp) nxt = 1;
        if (nxt == 1 && (m_state != 1 || !same)) m_mark = ecnt;
        m_state = nxt;
        m_prev  = lvl;
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        chk("state", 8'(state), 8'(m_state));
        chk("valve_open", 8'(valve), 8'(m_state == 1));
        chk("full", 8'(full), 8'(m_state == 2));
        chk("fault", 8'(fault), 8'(m_state == 3));
    endtask

    initial begin
        int lv, sv;
        reset = 1'b1; start = 1'b0; stop = 1'b0; clr = 1'b0;
        set_lvl(0); set_sp(42);
        step();
        chk("reset_state", 8'(state), 8'd0);
        reset = 1'b0;
        step();
        start = 1'b1;
        step();
        chk("start_valve", 8'(valve), 8'd1);
        start = 1'b0;
        for (int v = 1; v <= 42; v++) begin
            set_lvl(v);
            step();
            if (v == 41) chk("ramp41_valve", 8'(valve), 8'd1);
        end
        chk("at42_full", 8'(full), 8'd1);
        chk("at42_valve", 8'(valve), 8'd0);
        set_lvl(37);
        step();
        chk("hyst37_state", 8'(state), 8'd2);
        set_lvl(36);
        step();
        chk("hyst36_state", 8'(state), 8'd1);
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("wd_nofault", 8'(fault), 8'd0);
        end
        step();
        chk("wd_fault", 8'(fault), 8'd1);
        clr = 1'b1;
        step();
        chk("clear_idle", 8'(state), 8'd0);
        clr = 1'b0;
        set_lvl(10); start = 1'b1;
        step();
        chk("refill_state", 8'(state), 8'd1);
        start = 1'b0; lu = 4'hA; stop = 1'b1;
        step();
        chk("badbcd_state", 8'(state), 8'd3);
        stop = 1'b1; start = 1'b1;
        step();
        chk("fault_ignores_cmd", 8'(state), 8'd3);
        start = 1'b0; stop = 1'b0; clr = 1'b1;
        step();
        chk("clear_bad_held", 8'(state), 8'd3);
        set_lvl(10);
        step();
        chk("clear_valid_idle", 8'(state), 8'd0);
        clr = 1'b0; start = 1'b1; stop = 1'b1;
        step();
        chk("start_stop_idle", 8'(state), 8'd0);
        stop = 1'b0;
        step();
        chk("fill_again", 8'(valve), 8'd1);
        reset = 1'b1;
        step();
        chk("midfill_reset_state", 8'(state), 8'd0);
        chk("midfill_reset_valve", 8'(valve), 8'd0);
        chk("midfill_reset_fault", 8'(fault), 8'd0);
        reset = 1'b0;
        set_sp(0);
        step();
        chk("sp0_state", 8'(state), 8'd2);
        chk("sp0_valve", 8'(valve), 8'd0);
        start = 1'b0;
        step();
        chk("sp0_hold_valve", 8'(valve), 8'd0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        lv = 0; sv = 50;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, ((i / 100) % 2 == 1) ? 9 : 1) == 0)
                lv = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 99)) :
                     ((lv + int'($urandom_range(1, 3)) > 99) ? 0 : lv + int'($urandom_range(1, 3)));
            if ($urandom_range(0, 150) == 0) sv = int'($urandom_range(0, 99));
            set_lvl(lv);
            set_sp(sv);
            if ($urandom_range(0, 60) == 0) lu = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 80) == 0) st = 4'($urandom_range(10, 15));
            start = $urandom_range(0, 3) == 0;
            stop  = $urandom_range(0, 24) == 0;
            clr   = $urandom_range(0, 7) == 0;
            reset = $urandom_range(0, 300) == 0;
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/filling_tank_controller.md
FILLING_TANK_CONTROLLER -- requirements
Module: filling_tank_controller

Interface
REQ-001 SHALL have parameter WD_CYCLES, default 1000, meaning clock cycles without a level change before a FILLING fault.
REQ-002 SHALL have parameter HYST, default 5, meaning the refill hysteresis in level units.
REQ-003 SHALL have port clk  input  1  single system clock, rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port level_units  input  4  BCD units digit from the filling unit counter.
REQ-006 SHALL have port level_tens  input  4  BCD tens digit from the filling tens counter.
REQ-007 SHALL have port setpoint_units  input  4  BCD units digit of the target level.
REQ-008 SHALL have port setpoint_tens  input  4  BCD tens digit of the target level.
REQ-009 SHALL have port start  input  1  fill request, level-sampled each edge.
REQ-010 SHALL have port stop  input  1  abort request, level-sampled each edge.
REQ-011 SHALL have port clear_fault  input  1  fault acknowledge.
REQ-012 SHALL have port valve_open  output  1  drives the inlet valve.
REQ-013 SHALL have port full  output  1  target level reached.
REQ-014 SHALL have port fault  output  1  fault latched.
REQ-015 SHALL have port state  output  2  FSM state: IDLE=0, FILLING=1, FULL=2, FAULT=3.

Function
REQ-016 SHALL compute level = 10*tens + units and setpoint likewise, both as 7-bit unsigned values (0..99), combinationally from the ports.
REQ-017 SHALL treat any BCD digit above 9 on the level or setpoint ports as invalid.
REQ-018 SHALL register the state and drive outputs as a Moore decode of the state register: valve_open=1 only in FILLING, full=1 only in FULL, fault=1 only in FAULT.
REQ-019 SHALL move from IDLE, on start=1, to FULL if level >= setpoint, otherwise to FILLING; the new state and outputs SHALL be visible after the same edge.
REQ-020 SHALL move from FILLING to FULL when level >= setpoint, and to IDLE when stop=1.
REQ-021 SHALL move from FULL to IDLE when stop=1, and to FILLING when level + HYST < setpoint.
REQ-022 SHALL move from FAULT to IDLE only when clear_fault=1 and all inputs are valid BCD; it SHALL ignore start and stop while in FAULT.
REQ-023 SHALL move from any state other than FAULT to FAULT when any input is invalid BCD.
REQ-024 SHALL apply this per-edge priority: invalid BCD > stop > level >= setpoint > watchdog expiry > start.
REQ-025 SHALL register the previous level each cycle; the watchdog counter SHALL clear on entry to FILLING, on any level change, and in every state other than FILLING.
REQ-026 SHALL increment the watchdog once per cycle in FILLING while the level is unchanged, and SHALL move to FAULT on the edge where the count reaches WD_CYCLES-1.
REQ-027 SHALL treat setpoint=0 with start=1 as an immediate transition to FULL.
REQ-028 SHALL add no latency beyond one edge from sampled input to output change.

Reset
REQ-029 SHALL, on reset=1 at an edge, set state=IDLE, valve_open=0, full=0, fault=0, watchdog=0 and previous level=0, regardless of other inputs.
REQ-030 SHALL close the valve on the edge where reset is applied mid-fill, with no FAULT recorded.

Structure
REQ-031 SHALL take the state encoding enum and the constant BCD_MAX=9 from shared package filling_pkg.
REQ-032 SHALL instantiate sub-module bcd2_to_bin (two BCD digits to a 7-bit value plus a valid flag) once for the level and once for the setpoint.

Verification
REQ-033 SHALL test: setpoint 42, level 00, start pulse -> valve_open=1 next edge; ramp level to 42 -> FULL, valve_open=0 on the edge where level=42 is sampled.
REQ-034 SHALL test: in FULL with setpoint 42, level drops to 37 -> stays FULL; level 36 -> FILLING.
REQ-035 SHALL test: FILLING with WD_CYCLES=8 and level frozen -> fault=1 after 8 edges; clear_fault -> IDLE.
REQ-036 SHALL test: level_units=4'hA during FILLING -> FAULT next edge, even with stop=1 on the same edge.
REQ-037 SHALL test: start and stop both 1 in IDLE -> remains IDLE; reset asserted mid-fill -> IDLE, all outputs 0 after that edge.
REQ-038 SHALL test: setpoint 00 with start -> FULL directly, valve_open never 1.
